instr_fetch: RTL



---
 rtl/instr_fetch.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch stage feeding the combinational decoder.
// Keeps the program counter, issues one outstanding word read at a time to
// instruction memory, buffers returned words in a DEPTH-entry FIFO and
// presents the head with a valid/ready handshake. A branch redirect clears
// the FIFO and discards any in-flight fetch.
//
// Optional feature: define FETCH_MISALIGN_TRAP_EN to raise fetch_fault on a
// redirect to a non word aligned address. Without it the low two bits of the
// redirect target are silently cleared and fetch_fault is tied low.
//
// RESET_PC must be word aligned; DEPTH must be a power of two, >= 2.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic        fetch_fault
);

    localparam int unsigned   AW      = $clog2(DEPTH);
    localparam int unsigned   CW      = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // IDLE: nothing outstanding. REQ: outstanding, data will be kept.
    // FLUSH: outstanding, data will be dropped (a redirect happened meanwhile).
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FLUSH = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    state_e        state_q, state_d;
    logic          req_q, req_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   flush_pc_q, flush_pc_d;
    logic          fault_q, fault_d;

    entry_t        mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          valid_q, valid_d;
    entry_t        head_q, head_d;

    logic          push;
    logic          pop;
    logic          issue_ok;
    logic [31:0]   target_pc;
    entry_t        push_entry;

    // Redirect target is always fetched from a word boundary.
    assign target_pc = {redirect_pc[31:2], 2'b00};

`ifndef FETCH_MISALIGN_TRAP_EN
    // Low target bits are intentionally dropped when the trap is disabled.
    logic unused_pc_bits;
    assign unused_pc_bits = ^redirect_pc[1:0];
`endif

    // FIFO bookkeeping: push/pop decisions, pointer and occupancy next-state,
    // and the next value of the registered head outputs.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path can
        // leave it unassigned, which would otherwise infer a latch.
        push       = (state_q == REQ) && imem_ack && !redirect;
        pop        = valid_q && instr_ready && !redirect;
        push_entry = '{instr: imem_rdata, pc: addr_q};
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        head_d     = head_q;

        if (redirect) begin
            // Emptying is just collapsing the read pointer onto the write one.
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end

        // The head register follows the FIFO; when the FIFO drains it keeps
        // the last delivered word. A word written into the slot that becomes
        // the head this cycle bypasses the storage array.
        if (count_d != '0) begin
            if (push && (wr_ptr_q == rd_ptr_d)) begin
                head_d = push_entry;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
        valid_d = (count_d != '0);
    end

    // Fetch FSM next state: PC, flush target and fault flag.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        flush_pc_d = flush_pc_q;

`ifdef FETCH_MISALIGN_TRAP_EN
        fault_d = redirect ? (redirect_pc[1:0] != 2'b00) : fault_q;
`else
        fault_d = 1'b0;
`endif

        // Only issue when the word coming back next can certainly be stored.
        issue_ok = (count_d < DEPTH_C) && !fault_d;

        unique case (state_q)
            IDLE: begin
                if (redirect) begin
                    addr_d = target_pc;
                end
                if (issue_ok) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (imem_ack) begin
                    // Data is either pushed or, on a coinciding redirect, dropped.
                    addr_d  = redirect ? target_pc : addr_q + 32'd4;
                    state_d = issue_ok ? REQ : IDLE;
                end else if (redirect) begin
                    // Address must stay put until memory answers; remember target.
                    flush_pc_d = target_pc;
                    state_d    = FLUSH;
                end
            end
            FLUSH: begin
                if (imem_ack) begin
                    addr_d  = redirect ? target_pc : flush_pc_q;
                    state_d = issue_ok ? REQ : IDLE;
                end else if (redirect) begin
                    flush_pc_d = target_pc;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Fetch FSM outputs: a request is outstanding in every state but IDLE.
    always_comb begin
        req_d = (state_d != IDLE);
    end

    // State, PC and FIFO control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every register samples the values
        // from before this edge, independent of statement order.
        if (!rst_n) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            flush_pc_q <= '0;
            fault_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            head_q     <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            flush_pc_q <= flush_pc_d;
            fault_q    <= fault_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            head_q     <= head_d;
        end
    end

    // FIFO storage array.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; occupancy and the head register are
        // reset, so stale slot contents can never reach the outputs.
        if (push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    // Occupancy can never exceed the FIFO size.
    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) count_q <= DEPTH_C);

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr_valid = valid_q;
    assign instruction = head_q.instr;
    assign instr_pc    = head_q.pc;
    assign fetch_fault = fault_q;

endmodule
